// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranging controller: periodic trigger, echo timing in 1 MHz ticks,
// distance in cm with a one-cycle valid strobe and timeout flag.
module ultrasonic_ranger #(
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int US_PER_CM  = 58
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       ECHO,
  output logic       TRIG,
  output logic [9:0] DIST_CM,
  output logic       VALID,
  output logic       TIMEOUT
);

  localparam logic [15:0] PERIOD_M1 = 16'(PERIOD_US - 1);
  localparam logic [15:0] TRIG_M1   = 16'(TRIG_US - 1);
  localparam logic [15:0] TOUT_M1   = 16'(TIMEOUT_US - 1);
  localparam logic [5:0]  SUB_M1    = 6'(US_PER_CM - 1);
  localparam logic [9:0]  CM_MAX    = 10'd1023;

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE} state_t;

  state_t      state, state_n;
  logic        echo_m, echo_s, echo_p;
  logic        rise, fall, start;
  logic [15:0] pcnt, tcnt, tcnt_n;
  logic [5:0]  sub, sub_n;
  logic [9:0]  cm, cm_n, dist_n;
  logic        valid_n, tout_n;

  assign rise  = echo_s & ~echo_p;
  assign fall  = ~echo_s & echo_p;
  assign start = TICK && (pcnt == PERIOD_M1);

  // Echo synchronizer and free-running period counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_p <= 1'b0;
      pcnt   <= '0;
    end else begin
      echo_m <= ECHO;
      echo_s <= echo_m;
      echo_p <= echo_s;
      if (TICK) pcnt <= start ? 16'd0 : pcnt + 16'd1;
    end
  end

  // Measurement state and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      sub     <= '0;
      cm      <= '0;
      TRIG    <= 1'b0;
      DIST_CM <= '0;
      VALID   <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      state   <= state_n;
      tcnt    <= tcnt_n;
      sub     <= sub_n;
      cm      <= cm_n;
      TRIG    <= (state_n == S_TRIG);
      DIST_CM <= dist_n;
      VALID   <= valid_n;
      TIMEOUT <= tout_n;
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    sub_n   = sub;
    cm_n    = cm;
    dist_n  = DIST_CM;
    tout_n  = TIMEOUT;
    valid_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_TRIG;
          tcnt_n  = '0;
        end
      end
      S_TRIG: begin
        if (TICK) begin
          if (tcnt == TRIG_M1) begin
            state_n = S_WAIT_RISE;
            tcnt_n  = '0;
          end else begin
            tcnt_n = tcnt + 16'd1;
          end
        end
      end
      S_WAIT_RISE: begin
        if (TICK && tcnt == TOUT_M1) begin
          dist_n  = CM_MAX;
          tout_n  = 1'b1;
          valid_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          // Only an edge starts a measurement; an echo already high is ignored
          if (rise) begin
            state_n = S_MEASURE;
            sub_n   = '0;
            cm_n    = '0;
          end
          if (TICK) tcnt_n = tcnt + 16'd1;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          dist_n  = cm;
          tout_n  = 1'b0;
          valid_n = 1'b1;
          state_n = S_IDLE;
        end else if (TICK && tcnt == TOUT_M1) begin
          dist_n  = CM_MAX;
          tout_n  = 1'b1;
          valid_n = 1'b1;
          state_n = S_IDLE;
        end else if (TICK) begin
          tcnt_n = tcnt + 16'd1;
          if (sub == SUB_M1) begin
            sub_n = '0;
            if (cm != CM_MAX) cm_n = cm + 10'd1;
          end else begin
            sub_n = sub + 6'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
